// File: rtl/universal_shift_pkg.sv
// Shared op-code constants and control-state encoding for the universal shift register.
package universal_shift_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_CLR = 3'b000;  // clear
    localparam op_t OP_LD  = 3'b001;  // parallel load
    localparam op_t OP_LSR = 3'b010;  // logical right
    localparam op_t OP_LSL = 3'b011;  // logical left
    localparam op_t OP_ASR = 3'b100;  // arithmetic right
    localparam op_t OP_SIR = 3'b101;  // serial-in right
    localparam op_t OP_ROR = 3'b110;  // rotate right
    localparam op_t OP_ROL = 3'b111;  // rotate left

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Clear and load are single-edge ops that never touch sout or the step counter.
    function automatic logic is_shift_op(input op_t op);
        return (op != OP_CLR) && (op != OP_LD);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One single-bit step of any shift/rotate op: next register value and the bit shifted out.
module shift_step
    import universal_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  op_t              op,
    input  logic             inp,
    output logic [WIDTH-1:0] q_next,
    output logic             sout
);

    logic right_fill;
    logic left_fill;
    logic is_right;

    // Fill bit entering at the MSB for right-type ops and at the LSB for left-type ops.
    always_comb begin
        right_fill = 1'b0;
        left_fill  = 1'b0;
        is_right   = 1'b1;
        case (op)
            OP_LSR:  right_fill = 1'b0;
            OP_ASR:  right_fill = q[WIDTH-1];
            OP_SIR:  right_fill = inp;
            OP_ROR:  right_fill = q[0];
            OP_LSL:  begin is_right = 1'b0; left_fill = 1'b0;       end
            OP_ROL:  begin is_right = 1'b0; left_fill = q[WIDTH-1]; end
            default: is_right = 1'b1;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic from_left;
            logic from_right;
            if (gi == WIDTH - 1) begin : g_msb
                assign from_left = right_fill;
            end else begin : g_mid_r
                assign from_left = q[gi+1];
            end
            if (gi == 0) begin : g_lsb
                assign from_right = left_fill;
            end else begin : g_mid_l
                assign from_right = q[gi-1];
            end
            assign q_next[gi] = is_shift_op(op) ? (is_right ? from_left : from_right) : q[gi];
        end
    endgenerate

    assign sout = is_shift_op(op) ? (is_right ? q[0] : q[WIDTH-1]) : 1'b0;

endmodule

// File: rtl/universal_shift_reg.sv
// Multi-step universal shift register: an op is accepted in IDLE and its steps run one per falling edge.
module universal_shift_reg
    import universal_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       sel,
    input  logic [CNT_W-1:0] amt,
    input  logic             inp,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    op_t              op_reg,    op_next;
    logic [WIDTH-1:0] q_reg,     q_next;
    logic             sout_reg,  sout_next;
    logic             done_reg,  done_next;

    op_t              step_op;
    logic [WIDTH-1:0] step_q;
    logic             step_sout;

    // The first step is applied at the accepting edge, so the step unit sees sel directly in IDLE.
    assign step_op = (state_reg == ST_RUN) ? op_reg : op_t'(sel);

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q      (q_reg),
        .op     (step_op),
        .inp    (inp),
        .q_next (step_q),
        .sout   (step_sout)
    );

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= CNT_ZERO;
            op_reg    <= OP_CLR;
            q_reg     <= '0;
            sout_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            q_reg     <= q_next;
            sout_reg  <= sout_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        q_next     = q_reg;
        sout_next  = sout_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    op_next = op_t'(sel);
                    if (op_t'(sel) == OP_CLR) begin
                        q_next    = '0;
                        done_next = 1'b1;
                    end else if (op_t'(sel) == OP_LD) begin
                        q_next    = D;
                        done_next = 1'b1;
                    end else if (amt == CNT_ZERO) begin
                        done_next = 1'b1;
                    end else begin
                        q_next    = step_q;
                        sout_next = step_sout;
                        if (amt == CNT_ONE) begin
                            done_next = 1'b1;
                        end else begin
                            // Counter holds the steps still owed after this edge.
                            cnt_next   = amt - CNT_ONE;
                            state_next = ST_RUN;
                        end
                    end
                end
            end
            ST_RUN: begin
                q_next    = step_q;
                sout_next = step_sout;
                cnt_next  = cnt_reg - CNT_ONE;
                if (cnt_reg == CNT_ONE) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign Q    = q_reg;
    assign sout = sout_reg;
    assign busy = (state_reg == ST_RUN);
    assign done = done_reg;

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (minimum 2).
REQ-002 Parameter CNT_W, default 4, width of the shift-amount field.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  clock; all state updates on the falling edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  request an operation; sampled only in IDLE.
REQ-007 sel  input  3  operation code; latched at an accepted start.
REQ-008 amt  input  CNT_W  number of single-bit steps for shift ops; latched at an accepted start.
REQ-009 inp  input  1  serial-in bit; sampled at every step of op 101.
REQ-010 D  input  WIDTH  parallel load data.
REQ-011 Q  output  WIDTH  register contents.
REQ-012 sout  output  1  bit shifted out by the most recent step.
REQ-013 busy  output  1  multi-step operation in progress.
REQ-014 done  output  1  one-cycle pulse at operation completion.

Function
REQ-015 Op codes SHALL be: 000 clear; 001 load D; 010 logical right; 011 logical left; 100 arithmetic right (MSB kept); 101 serial-in right (inp into MSB); 110 rotate right; 111 rotate left.
REQ-016 The state machine SHALL have states IDLE and RUN, plus a remaining-step counter of CNT_W bits.
REQ-017 In IDLE with start=1 at a falling edge, the block SHALL accept the operation and apply the first step at that same edge.
REQ-018 Ops 000 and 001 SHALL complete at the accepting edge, ignoring amt; done=1 for the following cycle; busy stays 0.
REQ-019 A shift op with amt=N≥2 SHALL apply the first step at the accepting edge, enter RUN with busy=1, apply one step per edge, and return to IDLE at the edge applying step N.
REQ-020 At the edge applying the final step, busy SHALL drop to 0 and done SHALL rise for exactly one cycle.
REQ-021 A shift op with amt=1 SHALL behave like REQ-018: one step, done pulse, busy never asserted.
REQ-022 A shift op with amt=0 SHALL leave Q and sout unchanged and pulse done for one cycle.
REQ-023 Every right-type step SHALL set sout to the pre-step Q[0]; every left-type step SHALL set sout to the pre-step Q[WIDTH-1].
REQ-024 Ops 000 and 001 SHALL leave sout unchanged.
REQ-025 start SHALL be ignored while busy=1; the latched sel and amt SHALL NOT change during RUN.
REQ-026 start asserted in the same cycle that done is high SHALL be accepted normally, since the block is in IDLE.
REQ-027 Rotations with amt≥WIDTH SHALL simply perform amt steps, giving a net rotation of amt mod WIDTH.

Reset
REQ-028 rst=1 SHALL immediately force Q=0, sout=0, busy=0, done=0, the state to IDLE and the counter to 0, including during RUN.
REQ-029 After rst deasserts, the first start SHALL be accepted no earlier than the next falling edge.

Structure
REQ-030 Shared package universal_shift_pkg SHALL hold the op-code constants and the IDLE/RUN state encoding.
REQ-031 The single-step next-value and sout computation SHALL be a combinational sub-module shift_step (inputs Q, op, inp; outputs next Q, sout), instantiated once.

Verification (WIDTH=8, CNT_W=4)
REQ-032 Load: sel=001, D=0x81, start -> Q=0x81 after one edge; done high 1 cycle; busy never high.
REQ-033 Arithmetic right: Q=0x80, sel=100, amt=3 -> Q=0xF0 after 3 edges; busy high 2 cycles; done pulses after edge 3; sout=0.
REQ-034 Rotate left wrap: Q=0x81, sel=111, amt=9 -> Q=0x03 after 9 edges; sout=1.
REQ-035 Serial in: Q=0x00, sel=101, inp=1, amt=4 -> Q=0xF0; a start with sel=000 issued mid-RUN is ignored.
REQ-036 Reset mid-operation: Q=0xA5, sel=110, amt=5, rst asserted after 2 edges -> Q=0x00, busy=0, done=0 immediately; no done pulse follows.
REQ-037 amt=0: Q=0x3C, sel=010, amt=0 -> Q stays 0x3C; done pulses 1 cycle; sout unchanged.
